// File: rtl/span_cme_host.sv
// rtl/span_cme_host.sv - Avalon-MM initiator that loads a span_cme margin slave and polls for the result
module span_cme_host #(
    parameter int NUM_WORDS    = 34,
    parameter int CLEAR_OFFSET = 63,
    parameter int POLL_GAP     = 4,
    parameter int MAX_POLLS    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        chipselect,
    output logic        write,
    output logic        read,
    output logic [5:0]  offset,
    output logic [15:0] writeData,
    input  logic [15:0] readData,
    output logic [15:0] margin,
    output logic        margin_valid,
    output logic        timeout,
    output logic        busy
);

    localparam logic [5:0] IDX_LAST   = 6'(NUM_WORDS - 1);
    localparam logic [5:0] CLR_OFF    = 6'(CLEAR_OFFSET);
    localparam logic [7:0] GAP_LOAD   = 8'(POLL_GAP);
    localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_GAP,
        S_POLL_REQ,
        S_POLL_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [5:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] margin_q, margin_d;
    logic        mv_q, mv_d;
    logic        to_q, to_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  polls_q, polls_d;
    logic [7:0]  gap_q, gap_d;

    // Next-state and next bus cycle; every bus strobe defaults to idle so a
    // state must explicitly request each write or read.
    always_comb begin
        state_d  = state_q;
        cs_d     = 1'b0;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        off_d    = 6'd0;
        wdata_d  = 16'd0;
        margin_d = margin_q;
        mv_d     = 1'b0;
        to_d     = 1'b0;
        idx_d    = idx_q;
        polls_d  = polls_q;
        gap_d    = gap_q;

        case (state_q)
            S_IDLE: begin
                // A new job always begins with the engine-clear write so stale
                // slave state never leaks into the next calculation.
                if (in_valid) begin
                    state_d  = S_CLEAR;
                    cs_d     = 1'b1;
                    wr_d     = 1'b1;
                    off_d    = CLR_OFF;
                    margin_d = 16'd0;
                    idx_d    = 6'd0;
                    polls_d  = 8'd0;
                end
            end
            S_CLEAR: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    off_d   = idx_q;
                    wdata_d = in_data;
                    idx_d   = idx_q + 6'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q <= 8'd1) begin
                    state_d = S_POLL_REQ;
                    cs_d    = 1'b1;
                    rd_d    = 1'b1;
                    off_d   = 6'd0;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_POLL_REQ: begin
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                // A zero margin is indistinguishable from "not ready yet".
                polls_d = polls_q + 8'd1;
                if (readData != 16'd0) begin
                    margin_d = readData;
                    mv_d     = 1'b1;
                    state_d  = S_IDLE;
                end else if ((polls_q + 8'd1) >= POLL_LIMIT) begin
                    margin_d = 16'd0;
                    to_d     = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered bus outputs; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            off_q    <= 6'd0;
            wdata_q  <= 16'd0;
            margin_q <= 16'd0;
            mv_q     <= 1'b0;
            to_q     <= 1'b0;
            idx_q    <= 6'd0;
            polls_q  <= 8'd0;
            gap_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            margin_q <= margin_d;
            mv_q     <= mv_d;
            to_q     <= to_d;
            idx_q    <= idx_d;
            polls_q  <= polls_d;
            gap_q    <= gap_d;
        end
    end

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);
    assign chipselect   = cs_q;
    assign write        = wr_q;
    assign read         = rd_q;
    assign offset       = off_q;
    assign writeData    = wdata_q;
    assign margin       = margin_q;
    assign margin_valid = mv_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_span_cme_host.sv
// tb/tb_span_cme_host.sv - self-checking bench for span_cme_host against a job-level timeline model
module tb_span_cme_host;

    localparam int G = 4;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic [15:0] sd_a, sd_b;

    logic        rdy_a, cs_a, wr_a, rdo_a, mv_a, to_a, busy_a;
    logic [5:0]  off_a;
    logic [15:0] wd_a, mg_a;
    logic        rdy_b, cs_b, wr_b, rdo_b, mv_b, to_b, busy_b;
    logic [5:0]  off_b;
    logic [15:0] wd_b, mg_b;

    span_cme_host u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
        .chipselect(cs_a), .write(wr_a), .read(rdo_a), .offset(off_a), .writeData(wd_a),
        .readData(sd_a), .margin(mg_a), .margin_valid(mv_a), .timeout(to_a), .busy(busy_a)
    );

    span_cme_host #(.MAX_POLLS(3)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
        .chipselect(cs_b), .write(wr_b), .read(rdo_b), .offset(off_b), .writeData(wd_b),
        .readData(sd_b), .margin(mg_b), .margin_valid(mv_b), .timeout(to_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [15:0] mg;
        logic [15:0] wd;
        logic [5:0]  off;
        logic        cs, wr, rd, rdy, busy, mv, to;
    } exp_t;

    exp_t        ex [2][256];
    logic        s_rst [256];
    logic        s_v   [256];
    logic [15:0] s_d   [256];
    logic        s_chk [256];

    int          cyc = 0;
    bit          chk_on = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          job_id = 0;
    logic [15:0] pm [2];
    int          sl_zeros = 0;
    logic [15:0] sl_val = 16'd0;
    int          na_a = 0;
    int          na_b = 0;
    int          rd_cyc_a [$];

    // Slave model: read data appears one cycle after the strobe; the clear write restarts its poll count.
    always @(posedge clk) begin
        if (reset) begin
            na_a <= 0;
            sd_a <= 16'hBEEF;
        end else begin
            if (cs_a && wr_a && off_a == 6'd63) na_a <= 0;
            else if (rdo_a) na_a <= na_a + 1;
            sd_a <= rdo_a ? ((na_a < sl_zeros) ? 16'd0 : sl_val) : 16'hBEEF;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            na_b <= 0;
            sd_b <= 16'hBEEF;
        end else begin
            if (cs_b && wr_b && off_b == 6'd63) na_b <= 0;
            else if (rdo_b) na_b <= na_b + 1;
            sd_b <= rdo_b ? ((na_b < sl_zeros) ? 16'd0 : sl_val) : 16'hBEEF;
        end
    end

    task automatic chk(input int u, input string nm, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut=%0d job=%0d t=%0d got=%h want=%h", nm, u, job_id, cyc, got, want);
    endtask

    task automatic cmp(input int u, input exp_t e, input logic cs, input logic wr, input logic rdv,
                       input logic rdy, input logic bsy, input logic mv, input logic to,
                       input logic [5:0] off, input logic [15:0] wd, input logic [15:0] mg);
        chk(u, "chipselect", 16'(cs), 16'(e.cs));
        chk(u, "write", 16'(wr), 16'(e.wr));
        chk(u, "read", 16'(rdv), 16'(e.rd));
        chk(u, "in_ready", 16'(rdy), 16'(e.rdy));
        chk(u, "busy", 16'(bsy), 16'(e.busy));
        chk(u, "margin_valid", 16'(mv), 16'(e.mv));
        chk(u, "timeout", 16'(to), 16'(e.to));
        chk(u, "margin", mg, e.mg);
        if (e.cs) chk(u, "offset", 16'(off), 16'(e.off));
        if (e.wr) chk(u, "writeData", wd, e.wd);
    endtask

    // Single compare process: every checked cycle, both DUTs against the model timeline.
    always @(negedge clk) begin
        if (chk_on) begin
            if (s_chk[cyc]) begin
                cmp(0, ex[0][cyc], cs_a, wr_a, rdo_a, rdy_a, busy_a, mv_a, to_a, off_a, wd_a, mg_a);
                cmp(1, ex[1][cyc], cs_b, wr_b, rdo_b, rdy_b, busy_b, mv_b, to_b, off_b, wd_b, mg_b);
            end
            if (cyc == 0) rd_cyc_a.delete();
            if (rdo_a === 1'b1) rd_cyc_a.push_back(cyc);
        end
    end

    task automatic plan_reset(output int n);
        n = 4;
        for (int t = 0; t < 256; t++) begin
            s_rst[t] = (t < 2);
            s_v[t]   = (t < 2);
            s_d[t]   = 16'h5A5A;
            s_chk[t] = (t >= 1);
            ex[0][t] = '0;
            ex[1][t] = '0;
        end
        pm[0] = 16'd0;
        pm[1] = 16'd0;
    endtask

    // Job timeline from the rules: clear at t=1, LOAD from t=2, write k one cycle after its
    // handshake, first read G+1 cycles after the last handshake, reads every G+2 cycles,
    // result pulse two cycles after the deciding read. abort_k>0 resets after k words.
    task automatic plan_job(input int mode, input logic [15:0] base, input int z, input logic [15:0] v,
                            input int abort_k, output int n);
        int hs [34];
        int h_last, tr, mp, d, rt, endt [2];
        bit ok [2];
        for (int k = 0; k < 34; k++) hs[k] = (mode == 0) ? 2 + k : 2 + 2 * k;
        h_last = hs[33];
        tr = (abort_k > 0) ? hs[abort_k - 1] + 1 : -1;
        for (int u = 0; u < 2; u++) begin
            mp = (u == 0) ? 255 : 3;
            ok[u] = (z < mp);
            d = ok[u] ? z : mp - 1;
            endt[u] = (tr >= 0) ? tr + 1 : h_last + 1 + G + d * (G + 2) + 2;
            for (int t = 0; t < 256; t++) begin
                ex[u][t] = '0;
                ex[u][t].mg = (t == 0) ? pm[u] : 16'd0;
                if (!(tr >= 0 && t > tr)) begin
                    ex[u][t].busy = (t >= 1 && t < endt[u]);
                    ex[u][t].rdy  = (t >= 2 && t <= h_last);
                    if (t == 1) begin
                        ex[u][t].cs = 1'b1; ex[u][t].wr = 1'b1; ex[u][t].off = 6'd63; ex[u][t].wd = 16'd0;
                    end
                    for (int k = 0; k < 34; k++) begin
                        if (hs[k] + 1 == t) begin
                            ex[u][t].cs = 1'b1; ex[u][t].wr = 1'b1;
                            ex[u][t].off = 6'(k); ex[u][t].wd = 16'(base + k);
                        end
                    end
                    if (tr < 0) begin
                        for (int p = 0; p <= d; p++) begin
                            rt = h_last + 1 + G + p * (G + 2);
                            if (t == rt) begin
                                ex[u][t].cs = 1'b1; ex[u][t].rd = 1'b1; ex[u][t].off = 6'd0;
                            end
                        end
                        if (t >= endt[u]) ex[u][t].mg = ok[u] ? v : 16'd0;
                        if (t == endt[u]) begin
                            ex[u][t].mv = ok[u];
                            ex[u][t].to = !ok[u];
                        end
                    end
                end
            end
            pm[u] = (tr >= 0) ? 16'd0 : (ok[u] ? v : 16'd0);
        end
        n = ((endt[0] > endt[1]) ? endt[0] : endt[1]) + 3;
        for (int t = 0; t < 256; t++) begin
            s_rst[t] = (t == tr);
            s_chk[t] = 1'b1;
            s_v[t]   = (t < 2);
            s_d[t]   = (t < 2) ? base : 16'hDEAD;
            for (int k = 0; k < 34; k++) begin
                if (hs[k] == t) begin
                    s_v[t] = 1'b1;
                    s_d[t] = 16'(base + k);
                end
            end
            if (tr >= 0 && t >= tr) s_v[t] = 1'b0;
        end
        sl_zeros = z;
        sl_val   = v;
    endtask

    task automatic run(input int n);
        chk_on = 1;
        for (int t = 0; t < n; t++) begin
            reset    = s_rst[t];
            in_valid = s_v[t];
            in_data  = s_d[t];
            cyc      = t;
            @(posedge clk);
            #1;
        end
        chk_on = 0;
    endtask

    initial begin
        int n, r0, r2, r3;

        job_id = 0;
        plan_reset(n);
        run(n);

        job_id = 1;
        plan_job(0, 16'h0100, 3, 16'h1234, 0, n);
        run(n);
        chk(0, "read_count", 16'(na_a), 16'd4);
        chk(1, "read_count", 16'(na_b), 16'd3);
        chk(0, "margin_lit", mg_a, 16'h1234);
        chk(1, "margin_lit", mg_b, 16'h0000);
        chk(0, "read_strobes", 16'(rd_cyc_a.size()), 16'd4);
        if (rd_cyc_a.size() == 4) begin
            r0 = rd_cyc_a[0];
            r2 = rd_cyc_a[2];
            r3 = rd_cyc_a[3];
            chk(0, "first_read_cycle", 16'(r0), 16'd40);
            chk(0, "read_spacing", 16'(r3 - r2), 16'd6);
        end

        job_id = 2;
        plan_job(1, 16'h0200, 0, 16'h0055, 0, n);
        run(n);
        chk(0, "read_count", 16'(na_a), 16'd1);

        job_id = 3;
        plan_job(0, 16'h0300, 0, 16'h0077, 10, n);
        run(n);

        job_id = 4;
        plan_job(0, 16'h0400, 1, 16'hABCD, 0, n);
        run(n);
        chk(0, "read_count", 16'(na_a), 16'd2);
        chk(1, "margin_lit", mg_b, 16'hABCD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
